// File: rtl/operand_fetch.sv
// operand_fetch: decode-side producer for the ALU operand A/B registers.
// Reads rs_a then (unless use_imm) rs_b from a single-read-port register
// file whose data returns one cycle after the address, and presents opa/opb
// to execute through a valid/ready handshake.
//
// Optional feature: define OPF_BYPASS_EN to capture writeback data instead
// of rf_rdata when wb_en hits the operand index on the capture cycle.
// With the macro undefined the wb_* ports are present but ignored.
//
// Timing (accept edge = E0):
//   reg-reg : ADDR_A (read rs_a) -> ADDR_B (opa back, read rs_b)
//             -> LAST (opb back) -> OUT, op_valid high after E3
//   imm     : ADDR_A -> ADDR_B (opa back, opb<=imm) -> OUT, valid after E2
module operand_fetch #(
  parameter int DW      = 16,
  parameter int AW      = 4,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] rs_a,
  input  logic [AW-1:0] rs_b,
  input  logic          use_imm,
  input  logic [DW-1:0] imm,
  input  logic          flush,
  output logic [AW-1:0] rf_raddr,
  output logic          rf_re,
  input  logic [DW-1:0] rf_rdata,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] opa,
  output logic [DW-1:0] opb,
  output logic          op_valid,
  input  logic          op_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR_A = 3'd1,
    ADDR_B = 3'd2,
    LAST   = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t        state_q;
  logic [AW-1:0] rs_a_q;
  logic [AW-1:0] rs_b_q;
  logic          use_imm_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] opa_q;
  logic [DW-1:0] opb_q;
  logic          op_valid_q;
  logic          rf_re_q;
  logic [AW-1:0] rf_raddr_q;

  // Value that would be captured for each operand this cycle.
  logic [DW-1:0] cap_a_d;
  logic [DW-1:0] cap_b_d;

`ifndef OPF_BYPASS_EN
  // Writeback ports exist for interface compatibility only.
  logic unused_wb;
  assign unused_wb = wb_en ^ (^wb_addr) ^ (^wb_data);
`endif

  // Operand capture mux: register file data, optionally overridden by a
  // same-cycle writeback hit; index 0 forced to zero has the last word.
  always_comb begin
    cap_a_d = rf_rdata;
    cap_b_d = rf_rdata;
`ifdef OPF_BYPASS_EN
    if (wb_en && (wb_addr == rs_a_q)) cap_a_d = wb_data;
    if (wb_en && (wb_addr == rs_b_q)) cap_b_d = wb_data;
`endif
    if (ZERO_R0 && (rs_a_q == '0)) cap_a_d = '0;
    if (ZERO_R0 && (rs_b_q == '0)) cap_b_d = '0;
  end

  // Fetch sequencer; all outputs are registered. rf_re/rf_raddr are set on
  // entry to the state that issues the read, so data lands in the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rs_a_q     <= '0;
      rs_b_q     <= '0;
      use_imm_q  <= 1'b0;
      imm_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      op_valid_q <= 1'b0;
      rf_re_q    <= 1'b0;
      rf_raddr_q <= '0;
    end else if (flush) begin
      // Abort: operands keep their last values, nothing is presented.
      state_q    <= IDLE;
      op_valid_q <= 1'b0;
      rf_re_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rf_re_q <= 1'b0;
          if (req_valid) begin
            rs_a_q     <= rs_a;
            rs_b_q     <= rs_b;
            use_imm_q  <= use_imm;
            imm_q      <= imm;
            rf_re_q    <= 1'b1;
            rf_raddr_q <= rs_a;
            state_q    <= ADDR_A;
          end
        end
        ADDR_A: begin
          // Second read only when B comes from the register file.
          if (use_imm_q) begin
            rf_re_q <= 1'b0;
          end else begin
            rf_re_q    <= 1'b1;
            rf_raddr_q <= rs_b_q;
          end
          state_q <= ADDR_B;
        end
        ADDR_B: begin
          opa_q   <= cap_a_d;
          rf_re_q <= 1'b0;
          if (use_imm_q) begin
            opb_q      <= imm_q;
            op_valid_q <= 1'b1;
            state_q    <= OUT;
          end else begin
            state_q <= LAST;
          end
        end
        LAST: begin
          opb_q      <= cap_b_d;
          rf_re_q    <= 1'b0;
          op_valid_q <= 1'b1;
          state_q    <= OUT;
        end
        OUT: begin
          rf_re_q <= 1'b0;
          if (op_ready) begin
            op_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          rf_re_q    <= 1'b0;
          op_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rf_re     = rf_re_q;
  assign rf_raddr  = rf_raddr_q;
  assign opa       = opa_q;
  assign opb       = opb_q;
  assign op_valid  = op_valid_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural sync-read register file, scoreboard
// of expected operand pairs pushed on accept and popped on handshake.
module tb_operand_fetch;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] rs_a, rs_b;
  logic          use_imm;
  logic [DW-1:0] imm;
  logic          flush;
  logic [AW-1:0] rf_raddr;
  logic          rf_re;
  logic [DW-1:0] rf_rdata;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] opa, opb;
  logic          op_valid;
  logic          op_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } exp_t;
  exp_t sb[$];

  logic [DW-1:0] rf_mem [2**AW];

  operand_fetch #(.DW(DW), .AW(AW), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .rs_a(rs_a), .rs_b(rs_b), .use_imm(use_imm), .imm(imm), .flush(flush),
    .rf_raddr(rf_raddr), .rf_re(rf_re), .rf_rdata(rf_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .opa(opa), .opb(opb), .op_valid(op_valid), .op_ready(op_ready)
  );

  always #5 clk = ~clk;

  // Register file: data for the presented address one cycle after rf_re.
  always @(posedge clk) if (rf_re) rf_rdata <= rf_mem[rf_raddr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] idx);
    return (idx == '0) ? '0 : rf_mem[idx];
  endfunction

  // One full transaction: accept, read-address checks, latency, hold under
  // backpressure, then handshake and scoreboard compare.
  task automatic do_req(input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic ui, input logic [DW-1:0] im,
                        input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                        input int hold, input logic byp);
    int n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    if (!req_ready) begin chk("req_ready_timeout", 0, 1); return; end
    req_valid = 1'b1; rs_a = a; rs_b = b; use_imm = ui; imm = im;
    sb.push_back('{a: ea, b: eb});
    tick();
    req_valid = 1'b0; rs_a = '0; rs_b = '0; imm = '0; use_imm = 1'b0;
    chk("rd_a_re", rf_re, 1);
    chk("rd_a_addr", rf_raddr, a);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        chk("rd_b_re", rf_re, !ui);
        if (!ui) chk("rd_b_addr", rf_raddr, b);
        if (byp) begin wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'h7777; end
      end else if (n == 2) begin
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      end
    end while (!op_valid && n < 10);
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    if (!op_valid) begin
      chk("valid_timeout", 0, 1);
      void'(sb.pop_back());
      return;
    end
    chk("latency", n, ui ? 2 : 3);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", op_valid, 1);
      chk("hold_opa", opa, ea);
      chk("hold_opb", opb, eb);
    end
    op_ready = 1'b1;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("opa", opa, e.a);
      chk("opb", opb, e.b);
    end
    tick();
    op_ready = 1'b0;
    chk("valid_drop", op_valid, 0);
    chk("ready_back", req_ready, 1);
  endtask

  initial begin
    logic [AW-1:0] ra, rb;
    logic          ru;
    logic [DW-1:0] ri;
    int n;
    for (int i = 0; i < 2**AW; i++) rf_mem[i] = 16'h1000 + 16'(i) * 16'h0111;
    rf_mem[0] = 16'hFFFF; rf_mem[2] = 16'h00FF; rf_mem[3] = 16'h1234;
    rf_mem[4] = 16'h0001; rf_mem[5] = 16'hBEEF;
    rf_rdata = '0;
    rst_n = 1'b0; req_valid = 1'b0; rs_a = '0; rs_b = '0; use_imm = 1'b0;
    imm = '0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    op_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", op_valid, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_re", rf_re, 0);
    chk("rst_opa", opa, 0);
    rst_n = 1'b1;
    tick();

    // Register-register fetch.
    do_req(4'd3, 4'd5, 1'b0, 16'h0, 16'h1234, 16'hBEEF, 0, 1'b0);
    // Immediate with four cycles of backpressure.
    do_req(4'd2, 4'd9, 1'b1, 16'hA5A5, 16'h00FF, 16'hA5A5, 4, 1'b0);
    // Zero register on either side, RF returns nonzero for index 0.
    do_req(4'd0, 4'd5, 1'b0, 16'h0, 16'h0000, 16'hBEEF, 1, 1'b0);
    do_req(4'd3, 4'd0, 1'b0, 16'h0, 16'h1234, 16'h0000, 0, 1'b0);
    // Writeback hit on the opa capture cycle.
`ifdef OPF_BYPASS_EN
    do_req(4'd4, 4'd5, 1'b0, 16'h0, 16'h7777, 16'hBEEF, 0, 1'b1);
`else
    do_req(4'd4, 4'd5, 1'b0, 16'h0, 16'h0001, 16'hBEEF, 0, 1'b1);
`endif

    // Flush in ADDR_B: no output, IDLE next cycle, operands unchanged.
    req_valid = 1'b1; rs_a = 4'd6; rs_b = 4'd7;
    tick();
    req_valid = 1'b0;
    tick();                      // ADDR_B
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", req_ready, 1);
    chk("flush_re", rf_re, 0);
    chk("flush_opa_kept", opa, 16'h1234 ^ 16'h1234 ^ 16'h0001);
    n = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (op_valid) n++; end
    chk("flush_no_valid", n, 0);
    // Request alongside flush is dropped.
    req_valid = 1'b1; flush = 1'b1; rs_a = 4'd3;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_req_drop_ready", req_ready, 1);
    chk("flush_req_drop_re", rf_re, 0);
    do_req(4'd3, 4'd5, 1'b0, 16'h0, 16'h1234, 16'hBEEF, 0, 1'b0);

    // Flush beats op_ready in OUT.
    req_valid = 1'b1; rs_a = 4'd2; use_imm = 1'b1; imm = 16'h5A5A;
    tick();
    req_valid = 1'b0; use_imm = 1'b0;
    tick(); tick();
    chk("out_valid", op_valid, 1);
    op_ready = 1'b1; flush = 1'b1;
    tick();
    op_ready = 1'b0; flush = 1'b0;
    chk("out_flush_valid", op_valid, 0);
    chk("out_flush_ready", req_ready, 1);
    chk("out_flush_opb_kept", opb, 16'h5A5A);

    // Random mix against the register file model.
    for (int k = 0; k < 8; k++) begin
      ra = AW'($urandom_range(0, 15));
      rb = AW'($urandom_range(0, 15));
      ru = 1'($urandom_range(0, 1));
      ri = DW'($urandom);
      do_req(ra, rb, ru, ri, rd_model(ra), ru ? ri : rd_model(rb),
             int'($urandom_range(0, 2)), 1'b0);
    end

    // Reset held two cycles while in LAST.
    req_valid = 1'b1; rs_a = 4'd3; rs_b = 4'd5;
    tick();
    req_valid = 1'b0;
    tick(); tick();              // now in LAST, opa already captured
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", op_valid, 0);
    chk("mid_rst_opa", opa, 0);
    chk("mid_rst_opb", opb, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_raddr", rf_raddr, 0);
    tick();
    chk("post_rst_valid", op_valid, 0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Producer side of the operand-register interface. Accepts a decoded instruction's source indices, reads them from the single-read-port register file, and presents operand A and operand B to the execute stage.
- The execute-stage operand registers (A/B) consume the outputs through a valid/ready handshake.
- Sits between decode and the operand A/B registers feeding the ALU.

Parameters:
- DW, 16, operand/register data width
- AW, 4, register index width (2^AW registers)
- ZERO_R0, 1, when 1 register index 0 always reads as zero

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  decode presents an instruction
- req_ready  output  1  block can accept a request
- rs_a  input  AW  source A index
- rs_b  input  AW  source B index
- use_imm  input  1  operand B taken from imm, rs_b ignored
- imm  input  DW  immediate value
- flush  input  1  abort in-flight fetch
- rf_raddr  output  AW  register file read address
- rf_re  output  1  register file read enable
- rf_rdata  input  DW  read data, valid the cycle after rf_re/rf_raddr
- wb_en  input  1  writeback write strobe (used only with bypass)
- wb_addr  input  AW  writeback index
- wb_data  input  DW  writeback data
- opa  output  DW  operand A
- opb  output  DW  operand B
- op_valid  output  1  opa/opb valid
- op_ready  input  1  execute stage accepts operands

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; opa=0, opb=0, op_valid=0, rf_re=0, rf_raddr=0, internal index/imm latches=0. Reset overrides flush and all other inputs, and aborts any state.
- req_ready=1 only in IDLE (combinational from state).
- FSM states: IDLE, ADDR_A, ADDR_B, LAST, OUT.
- IDLE: on req_valid&&req_ready, latch rs_a, rs_b, use_imm, imm; go to ADDR_A.
- ADDR_A: rf_re=1, rf_raddr=rs_a latch; go to ADDR_B.
- ADDR_B: capture opa from rf_rdata.
  - use_imm=1: opb<=imm, rf_re=0, go to OUT.
  - use_imm=0: rf_re=1, rf_raddr=rs_b latch, go to LAST.
- LAST: capture opb from rf_rdata; go to OUT.
- OUT: op_valid=1. opa/opb are held stable while op_valid=1 and op_ready=0. On op_ready=1: op_valid drops the next cycle and state goes to IDLE.
- No new request is accepted in the same cycle as the handover; IDLE takes at least one cycle.
- Latency from the accept edge to op_valid high: 3 cycles for a register-register request, 2 cycles for immediate.
- rf_re=0 and rf_raddr holds its last value in IDLE, LAST, and OUT.
- ZERO_R0=1: a captured operand whose index is 0 is forced to 0 regardless of rf_rdata or bypass. The read is still issued.
- flush=1 (rst_n=1): next state IDLE, op_valid=0, rf_re=0 from the next cycle. opa/opb keep their values. A request presented in the same cycle as flush is not accepted.
- Simultaneous op_ready and flush in OUT: flush wins. The operands are treated as not consumed; the execute stage must ignore them.

Optional Feature:
- Macro OPF_BYPASS_EN.
- Defined: when capturing an operand (opa in ADDR_B, opb in LAST), if wb_en=1 and wb_addr equals that operand's index, capture wb_data instead of rf_rdata. The ZERO_R0 rule still takes priority. The bypass is checked only on the capture cycle.
- Not defined: wb_en, wb_addr and wb_data are ignored (ports remain); operands always come from rf_rdata.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-fetch (in LAST) -> next cycle state IDLE, op_valid=0, opa=opb=0, req_ready=1.
- Register-register: RF[3]=16'h1234, RF[5]=16'hBEEF; request rs_a=3, rs_b=5, use_imm=0 -> rf_raddr 3 then 5; op_valid high on 3rd cycle after accept; opa=16'h1234, opb=16'hBEEF.
- Immediate plus backpressure: rs_a=2 (RF[2]=16'h00FF), use_imm=1, imm=16'hA5A5, op_ready=0 for 4 cycles -> op_valid after 2 cycles, values stable for 4 cycles; op_ready=1 -> op_valid=0 next cycle, req_ready=1.
- Zero register: ZERO_R0=1, rs_a=0 with RF returning 16'hFFFF -> opa=16'h0000.
- Flush: assert flush in ADDR_B -> op_valid never rises; IDLE next cycle; a following request rs_a=3, rs_b=5 returns 16'h1234/16'hBEEF.
- Bypass: RF[4]=16'h0001, wb_en=1, wb_addr=4, wb_data=16'h7777 on the opa capture cycle -> with OPF_BYPASS_EN opa=16'h7777; without it opa=16'h0001.
